// File: rtl/add_sequencer.sv
// Moore control sequencer for a three-register accumulate datapath: loads an
// immediate into RA, copies it to RB, then performs N passes of RB <= A + RB.
module add_sequencer #(
    parameter int CNT_W = 4
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    output logic             RAin,
    output logic             RBin,
    output logic             RZin,
    output logic             RAout,
    output logic             RBout,
    output logic             RZout,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] remaining
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOADA = 3'd1,
        S_XFER  = 3'd2,
        S_ADD   = 3'd3,
        S_WB    = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_remaining;
    logic [CNT_W-1:0] w_next_remaining;
    // Packed as {busy, done, RAin, RBin, RZin, RAout, RBout, RZout}
    logic [7:0]       r_outs;

    function automatic logic [7:0] decode_outs(input state_t s);
        case (s)
            S_LOADA: decode_outs = 8'b1010_0000;
            S_XFER:  decode_outs = 8'b1001_0100;
            S_ADD:   decode_outs = 8'b1000_1010;
            S_WB:    decode_outs = 8'b1001_0001;
            S_DONE:  decode_outs = 8'b0100_0000;
            default: decode_outs = 8'b0000_0000;
        endcase
    endfunction

    always_comb begin
        w_next_state     = r_state;
        w_next_remaining = r_remaining;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state     = S_LOADA;
                    w_next_remaining = count;
                end
            end
            S_LOADA: w_next_state = S_XFER;
            S_XFER:  w_next_state = (r_remaining == '0) ? S_DONE : S_ADD;
            S_ADD:   w_next_state = S_WB;
            S_WB: begin
                // Only reachable with remaining >= 1, so this never wraps
                w_next_remaining = r_remaining - CNT_W'(1);
                w_next_state     = (r_remaining == CNT_W'(1)) ? S_DONE : S_ADD;
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they stay a pure Moore decode
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            r_state     <= S_IDLE;
            r_remaining <= '0;
            r_outs      <= '0;
        end else begin
            r_state     <= w_next_state;
            r_remaining <= w_next_remaining;
            r_outs      <= decode_outs(w_next_state);
        end
    end

    assign {busy, done, RAin, RBin, RZin, RAout, RBout, RZout} = r_outs;
    assign remaining = r_remaining;

endmodule
